// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder and the pipeline memory stage:
// access-size encodings, responder FSM states and byte-lane helpers.
package data_mem_responder_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } mem_state_e;

   // Encoding 2'b11 is treated as a word access.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      case (size)
         SIZE_BYTE: is_misaligned = 1'b0;
         SIZE_HALF: is_misaligned = off[0];
         default:   is_misaligned = (off != 2'b00);
      endcase
   endfunction

   function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] off);
      case (size)
         SIZE_BYTE: byte_mask = 4'b0001 << off;
         SIZE_HALF: byte_mask = 4'b0011 << {off[1], 1'b0};
         default:   byte_mask = 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with per-byte write enables and a registered read port.
// Contents are never reset.
module dmem_array #(
   parameter int DEPTH_WORDS = 1024
) (
   input  logic                           i_clk,
   input  logic                           i_we,
   input  logic [3:0]                     i_be,
   input  logic                           i_re,
   input  logic [$clog2(DEPTH_WORDS)-1:0] i_idx,
   input  logic [31:0]                    i_wdata,
   output logic [31:0]                    o_rdata
);

   logic [31:0] r_mem [DEPTH_WORDS];
   logic [31:0] r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         for (int b = 0; b < 4; b++) begin
            if (i_be[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
         end
      end
      if (i_re) r_rdata <= r_mem[i_idx];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency data-memory responder: accepts one load/store at a time and
// answers with a one-cycle valid strobe LATENCY cycles after acceptance.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready; a request with i_mem_en=1 is accepted
// ST_WAIT | request latched, latency down-counter running
// ST_RESP | o_mem_valid high for one cycle, read data presented
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int DEPTH_WORDS   = 1024,
   parameter int LATENCY       = 2
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_mem_en,
   input  logic                     i_mem_rd_wr,
   input  logic [ADDRESS_WIDTH-1:0] i_mem_addr,
   input  logic [DATA_WIDTH-1:0]    i_mem_data_in,
   input  logic [1:0]               i_size,
   input  logic [1:0]               i_byte_off,
   output logic [DATA_WIDTH-1:0]    o_mem_data_out,
   output logic                     o_mem_valid,
   output logic                     o_mem_busy,
   output logic                     o_misaligned
);

   localparam int         IDX_W    = $clog2(DEPTH_WORDS);
   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   mem_state_e            r_state;
   mem_state_e            w_state_nxt;
   logic [3:0]            r_cnt;
   logic                  r_rd_wr;
   logic                  r_mis;
   logic [IDX_W-1:0]      r_idx;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [3:0]            r_be;

   logic                  w_accept;
   logic                  w_enter_resp;
   logic [IDX_W-1:0]      w_in_idx;
   logic                  w_op_wr;
   logic                  w_op_mis;
   logic [IDX_W-1:0]      w_op_idx;
   logic [DATA_WIDTH-1:0] w_op_wdata;
   logic [3:0]            w_op_be;
   logic                  w_ram_we;
   logic                  w_ram_re;
   logic [31:0]           w_rdata;
   logic                  w_unused;

   assign w_in_idx = i_mem_addr[IDX_W+1:2];
   assign w_accept = (r_state == ST_IDLE) && i_mem_en && !i_rst;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (i_mem_en) w_state_nxt = (LATENCY == 1) ? ST_RESP : ST_WAIT;
         ST_WAIT: if (r_cnt <= 4'd1) w_state_nxt = ST_RESP;
         ST_RESP: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign w_enter_resp = (w_state_nxt == ST_RESP) && (r_state != ST_RESP) && !i_rst;

   // With LATENCY=1 the RAM access happens on the accept edge itself,
   // before the request registers have been loaded.
   assign w_op_wr    = (r_state == ST_IDLE) ? i_mem_rd_wr                     : r_rd_wr;
   assign w_op_mis   = (r_state == ST_IDLE) ? is_misaligned(i_size, i_byte_off) : r_mis;
   assign w_op_idx   = (r_state == ST_IDLE) ? w_in_idx                        : r_idx;
   assign w_op_wdata = (r_state == ST_IDLE) ? i_mem_data_in                   : r_wdata;
   assign w_op_be    = (r_state == ST_IDLE) ? byte_mask(i_size, i_byte_off)   : r_be;

   assign w_ram_we = w_enter_resp && w_op_wr && !w_op_mis;
   assign w_ram_re = w_enter_resp && !w_op_wr && !w_op_mis;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
         r_rd_wr <= 1'b0;
         r_mis   <= 1'b0;
         r_idx   <= '0;
         r_wdata <= '0;
         r_be    <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_cnt   <= CNT_LOAD;
            r_rd_wr <= i_mem_rd_wr;
            r_mis   <= is_misaligned(i_size, i_byte_off);
            r_idx   <= w_in_idx;
            r_wdata <= i_mem_data_in;
            r_be    <= byte_mask(i_size, i_byte_off);
         end else if (r_state == ST_WAIT) begin
            r_cnt <= r_cnt - 4'd1;
         end
      end
   end

   dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_dmem_array (
      .i_clk   (i_clk),
      .i_we    (w_ram_we),
      .i_be    (w_op_be),
      .i_re    (w_ram_re),
      .i_idx   (w_op_idx),
      .i_wdata (w_op_wdata),
      .o_rdata (w_rdata)
   );

   assign o_mem_valid    = (r_state == ST_RESP);
   assign o_mem_busy     = (r_state != ST_IDLE);
   assign o_misaligned   = (r_state == ST_RESP) && r_mis;
   assign o_mem_data_out = ((r_state == ST_RESP) && !r_rd_wr && !r_mis) ? w_rdata : '0;

   // Address bits outside the word index are intentionally ignored.
   assign w_unused = ^i_mem_addr;

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 32, byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width; only 32 is supported.
REQ-003 SHALL have parameter DEPTH_WORDS, default 1024, storage depth in words, power of two.
REQ-004 SHALL have parameter LATENCY, default 2, accept-to-response cycles, legal range 1..15.
REQ-005 SHALL have port i_clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port i_rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port i_mem_en  input  1  request present.
REQ-008 SHALL have port i_mem_rd_wr  input  1  0 load, 1 store.
REQ-009 SHALL have port i_mem_addr  input  ADDRESS_WIDTH  word-aligned address; bits [1:0] ignored.
REQ-010 SHALL have port i_mem_data_in  input  DATA_WIDTH  store data, already placed in its byte lanes.
REQ-011 SHALL have port i_size  input  2  00 byte, 01 half, 10/11 word.
REQ-012 SHALL have port i_byte_off  input  2  original address bits [1:0].
REQ-013 SHALL have port o_mem_data_out  output  DATA_WIDTH  full read word, unshifted.
REQ-014 SHALL have port o_mem_valid  output  1  one-cycle response strobe.
REQ-015 SHALL have port o_mem_busy  output  1  request in flight; upstream stalls.
REQ-016 SHALL have port o_misaligned  output  1  qualifies o_mem_valid; access rejected.

Function
REQ-017 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; WAIT is skipped when LATENCY=1.
REQ-018 SHALL accept a request only in IDLE with i_mem_en=1, latching rd_wr, addr, data, size and byte_off.
REQ-019 SHALL raise o_mem_valid exactly LATENCY cycles after the accept cycle, for one cycle, in RESP.
REQ-020 SHALL drive o_mem_busy=1 in WAIT and RESP and 0 in IDLE.
REQ-021 SHALL ignore i_mem_en outside IDLE; upstream holds the request until o_mem_valid.
REQ-022 SHALL treat i_mem_en=1 in the cycle after o_mem_valid as a new request.
REQ-023 SHALL use a down-counter of 4 bits, loaded with LATENCY-1 on accept, that leaves WAIT on reaching 1.
REQ-024 SHALL form the word index as addr[log2(DEPTH_WORDS)+1:2]; upper bits are ignored, so addresses wrap.
REQ-025 SHALL generate the byte mask: byte = 1<<off; half = 4'b0011<<(2*off[1]); word = 4'b1111.
REQ-026 SHALL flag as misaligned a half with off[0]=1 or a word with off!=0; no write is made and o_mem_data_out is 0.
REQ-027 SHALL commit a store's masked lanes on the edge entering RESP; unmasked lanes are unchanged.
REQ-028 SHALL register the load word on the edge entering RESP and hold it on o_mem_data_out during RESP only, 0 otherwise.
REQ-029 SHALL return 0 on o_mem_data_out for a store.
REQ-030 SHALL return post-write data to a load accepted after a store's o_mem_valid.
REQ-031 SHALL assert o_misaligned only together with o_mem_valid.

Reset
REQ-032 SHALL, with i_rst=1 at an edge, force IDLE and counter 0; o_mem_data_out=0, o_mem_valid=0, o_mem_busy=0, o_misaligned=0.
REQ-033 SHALL drop a request reset mid-flight with no response; a store not yet committed is not written.
REQ-034 SHALL not clear or initialise storage contents on reset.
REQ-035 SHALL accept no request in the cycle i_rst=1.

Structure
REQ-036 SHALL place the size encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD) and the FSM state enum in the shared package used by the pipeline memory stage.
REQ-037 SHALL instantiate one sub-module, dmem_array: a DEPTH_WORDS x 32 byte-write-enable synchronous RAM with a registered read port.

Verification (LATENCY=2 unless stated)
REQ-038 SHALL cover: store word 0xDEADBEEF at 0x10, then load 0x10 -> o_mem_valid 2 cycles after each accept; the load returns 0xDEADBEEF with o_misaligned=0.
REQ-039 SHALL cover: word 0x11223344 at 0x20, store byte data 0x00AA0000 with off=2, then load -> 0x11AA3344.
REQ-040 SHALL cover: store half with off=1 at 0x20 -> o_misaligned=1 with o_mem_valid; a following load returns the word unchanged.
REQ-041 SHALL cover: i_mem_en held high through busy -> exactly one response per request; busy pattern 1,1,0.
REQ-042 SHALL cover: i_rst asserted the cycle after a store accept to 0x30 -> no o_mem_valid; a following load of 0x30 returns the prior contents.
REQ-043 SHALL cover: DEPTH_WORDS=1024, store 0x5A5A5A5A to 0x1000, load 0x0000 -> 0x5A5A5A5A (wrap).
